// File: rtl/unified_mem_arbiter_if.sv
// Bus bundle between the core/DMA requesters, the unified memory port and the arbiter.
// master = requester/memory side, slave = arbiter.
interface unified_mem_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_adr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_stall;

    logic          dma_req;
    logic          dma_we;
    logic [AW-1:0] dma_adr;
    logic [DW-1:0] dma_wdata;
    logic          dma_ack;
    logic [DW-1:0] dma_rdata;

    logic [AW-1:0] mem_adr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    modport master (
        output cpu_req, cpu_we, cpu_adr, cpu_wdata,
        input  cpu_ack, cpu_rdata, cpu_stall,
        output dma_req, dma_we, dma_adr, dma_wdata,
        input  dma_ack, dma_rdata,
        input  mem_adr, mem_wdata, mem_we, busy,
        output mem_rdata
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_adr, cpu_wdata,
        output cpu_ack, cpu_rdata, cpu_stall,
        input  dma_req, dma_we, dma_adr, dma_wdata,
        output dma_ack, dma_rdata,
        output mem_adr, mem_wdata, mem_we, busy,
        input  mem_rdata
    );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Round-robin arbiter sharing the unified instruction/data memory port between the
// multicycle core and the DMA/program loader, one access at a time over MEM_LAT cycles.
module unified_mem_arbiter #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    unified_mem_arbiter_if.slave bus
);

    localparam int unsigned     CW      = $clog2(MEM_LAT) + 1;
    localparam logic [CW-1:0]   LAT_M1  = CW'(MEM_LAT - 1);
    localparam logic [CW-1:0]   CNT_ONE = CW'(1);
    localparam bit              LAT_ONE = (MEM_LAT == 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic SEL_CPU = 1'b0;
    localparam logic SEL_DMA = 1'b1;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          owner_q, owner_d;
    logic          last_q, last_d;
    logic          we_q, we_d;
    logic          turn_q, turn_d;
    logic [AW-1:0] mem_adr_q, mem_adr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          mem_we_q, mem_we_d;
    logic          cpu_ack_q, cpu_ack_d;
    logic          dma_ack_q, dma_ack_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0] dma_rdata_q, dma_rdata_d;
    logic          busy_q, busy_d;
    logic          sel_dma_c;
    logic          capture_c;

    // Next-state and output logic; turn_q gives requesters one IDLE cycle after their ack
    // to drop or retarget req before the next grant is taken.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_d     = owner_q;
        last_d      = last_q;
        we_d        = we_q;
        turn_d      = 1'b0;
        mem_adr_d   = mem_adr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        cpu_ack_d   = 1'b0;
        dma_ack_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        capture_c   = 1'b0;
        sel_dma_c   = bus.dma_req & (~bus.cpu_req | (last_q == SEL_CPU));

        case (state_q)
            S_IDLE: begin
                if (~turn_q & (bus.cpu_req | bus.dma_req)) begin
                    owner_d     = sel_dma_c;
                    last_d      = sel_dma_c;
                    mem_adr_d   = sel_dma_c ? bus.dma_adr   : bus.cpu_adr;
                    mem_wdata_d = sel_dma_c ? bus.dma_wdata : bus.cpu_wdata;
                    we_d        = sel_dma_c ? bus.dma_we    : bus.cpu_we;
                    mem_we_d    = we_d;
                    state_d     = S_ACCESS;
                end
            end
            S_ACCESS: begin
                cnt_d = LAT_M1;
                if (LAT_ONE) begin
                    capture_c = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    capture_c = 1'b1;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                turn_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // Last latency cycle: latch read data for the owner and arm its ack for DONE.
        if (capture_c) begin
            if (owner_q == SEL_DMA) begin
                dma_ack_d = 1'b1;
                if (!we_q) dma_rdata_d = bus.mem_rdata;
            end else begin
                cpu_ack_d = 1'b1;
                if (!we_q) cpu_rdata_d = bus.mem_rdata;
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            owner_q     <= SEL_CPU;
            last_q      <= SEL_DMA;
            we_q        <= 1'b0;
            turn_q      <= 1'b0;
            mem_adr_q   <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            cpu_ack_q   <= 1'b0;
            dma_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            we_q        <= we_d;
            turn_q      <= turn_d;
            mem_adr_q   <= mem_adr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            cpu_ack_q   <= cpu_ack_d;
            dma_ack_q   <= dma_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.mem_adr   = mem_adr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.cpu_ack   = cpu_ack_q;
    assign bus.dma_ack   = dma_ack_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.dma_rdata = dma_rdata_q;
    assign bus.busy      = busy_q;
    assign bus.cpu_stall = bus.cpu_req & ~cpu_ack_q;

endmodule
